// File: rtl/bitstream_pkg.sv
// Shared definitions for the byte/bitstream serializer and deserializer pair.
// Holds the byte and bit-counter widths, the serializer state type, the
// bit-order selector constants and a helper that picks the leading bit of a byte.
package bitstream_pkg;

  localparam int BYTE_W    = 8;
  localparam int BIT_CNT_W = 3;

  localparam bit MSB_FIRST_ORDER = 1'b1;
  localparam bit LSB_FIRST_ORDER = 1'b0;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  // Bit that goes on the wire first for a byte held in a shift register.
  function automatic logic lead_bit(input logic [BYTE_W-1:0] b, input bit msb_first);
    return msb_first ? b[BYTE_W-1] : b[0];
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Synchronous FIFO_DEPTH x 8 byte FIFO.
// Ports:
//   clk, rst        - clock, synchronous active-high reset (empties the FIFO)
//   wr_en, wr_data  - push a byte; ignored while full
//   rd_en           - pop the head byte; ignored while empty
//   rd_data         - head entry, combinational
//   full, empty     - occupancy flags
// Pointers carry one extra wrap bit so full and empty can be told apart
// when the index bits match.
module byte_fifo
  import bitstream_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [BYTE_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  localparam int IDX_W = $clog2(FIFO_DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [BYTE_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic              w_push;
  logic              w_pop;

  assign full  = (r_wr_ptr[IDX_W-1:0] == r_rd_ptr[IDX_W-1:0]) &&
                 (r_wr_ptr[IDX_W] != r_rd_ptr[IDX_W]);
  assign empty = (r_wr_ptr == r_rd_ptr);

  assign w_push = wr_en && !full;
  assign w_pop  = rd_en && !empty;

  assign rd_data = r_mem[r_rd_ptr[IDX_W-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
    end
  end

  // Storage needs no reset: stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[IDX_W-1:0]] <= wr_data;
  end

endmodule

// File: rtl/byte_to_bitstream.sv
// Byte-to-serial converter: bytes enter a small FIFO over valid/ready and
// leave as a gap-free one-bit-per-clock stream with a per-bit valid.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   data_in         - byte offered for transfer
//   data_in_valid   - data_in is valid this cycle
//   data_in_ready   - FIFO not full (no path from data_in_valid)
//   data_out        - serial bit (registered)
//   data_out_valid  - data_out carries a bit this cycle (registered)
//   busy            - a byte is shifting or the FIFO holds data
//
// state | meaning
// IDLE  | nothing on the wire; load the head byte as soon as the FIFO has one
// SHIFT | a byte is on the wire, r_bit_cnt = index of the bit being presented
module byte_to_bitstream
  import bitstream_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter bit MSB_FIRST  = MSB_FIRST_ORDER
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] data_in,
  input  logic              data_in_valid,
  output logic              data_in_ready,
  output logic              data_out,
  output logic              data_out_valid,
  output logic              busy
);

  ser_state_t           r_state;
  logic [BYTE_W-1:0]    r_shreg;
  logic [BIT_CNT_W-1:0] r_bit_cnt;
  logic                 r_data_out;
  logic                 r_data_out_valid;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_pop;
  logic                 w_last_bit;
  logic [BYTE_W-1:0]    w_head;
  logic [BYTE_W-1:0]    w_shifted;

  byte_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (data_in_valid),
    .wr_data (data_in),
    .rd_en   (w_pop),
    .rd_data (w_head),
    .full    (w_full),
    .empty   (w_empty)
  );

  assign w_last_bit = (r_state == SHIFT) && (r_bit_cnt == BIT_CNT_W'(BYTE_W - 1));
  // Pop from IDLE, or on the last bit so the next byte follows without a gap.
  assign w_pop      = !w_empty && ((r_state == IDLE) || w_last_bit);
  assign w_shifted  = MSB_FIRST ? (r_shreg << 1) : (r_shreg >> 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= IDLE;
      r_shreg          <= '0;
      r_bit_cnt        <= '0;
      r_data_out       <= 1'b0;
      r_data_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_shreg          <= w_head;
            r_bit_cnt        <= '0;
            r_data_out       <= lead_bit(w_head, MSB_FIRST);
            r_data_out_valid <= 1'b1;
            r_state          <= SHIFT;
          end
        end
        SHIFT: begin
          if (!w_last_bit) begin
            r_shreg    <= w_shifted;
            r_bit_cnt  <= r_bit_cnt + BIT_CNT_W'(1);
            r_data_out <= lead_bit(w_shifted, MSB_FIRST);
          end else if (!w_empty) begin
            r_shreg          <= w_head;
            r_bit_cnt        <= '0;
            r_data_out       <= lead_bit(w_head, MSB_FIRST);
            r_data_out_valid <= 1'b1;
          end else begin
            r_shreg          <= '0;
            r_bit_cnt        <= '0;
            r_data_out       <= 1'b0;
            r_data_out_valid <= 1'b0;
            r_state          <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign data_in_ready  = !w_full;
  assign data_out       = r_data_out;
  assign data_out_valid = r_data_out_valid;
  assign busy           = (r_state == SHIFT) || !w_empty;

endmodule

// File: tb/tb_byte_to_bitstream.sv
// Bench for byte_to_bitstream: one MSB-first and one LSB-first instance share
// the same input stimulus. A queue-based reference model predicts ready, valid,
// bit and busy every cycle; directed vectors and sequences cover latency,
// back-to-back bytes, FIFO full back-pressure and reset mid-byte.
module tb_byte_to_bitstream;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       vin;
  logic       rdy_m, dout_m, dv_m, busy_m;
  logic       rdy_l, dout_l, dv_l, busy_l;

  int n_checks = 0;
  int n_err    = 0;
  bit en_cmp   = 1'b0;

  always #5 clk = ~clk;

  byte_to_bitstream #(.FIFO_DEPTH(DEPTH), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .data_in(din), .data_in_valid(vin),
    .data_in_ready(rdy_m), .data_out(dout_m), .data_out_valid(dv_m), .busy(busy_m)
  );

  byte_to_bitstream #(.FIFO_DEPTH(DEPTH), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .data_in(din), .data_in_valid(vin),
    .data_in_ready(rdy_l), .data_out(dout_l), .data_out_valid(dv_l), .busy(busy_l)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a byte queue plus the list of bits still to appear on
  // each wire. Ready is occupancy below depth; a byte moves to the wire when
  // the wire has at most its last bit left.
  logic [7:0] mq[$];
  bit         bm[$];
  bit         bl[$];
  logic [7:0] acc[$];
  logic [7:0] got[$];
  bit         m_full, m_pop;
  logic [7:0] m_b;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete(); bm.delete(); bl.delete();
    end else begin
      m_full = (mq.size() == DEPTH);
      m_pop  = (mq.size() != 0) && (bm.size() <= 1);
      if (bm.size() != 0) begin bm.delete(0); bl.delete(0); end
      if (m_pop) begin
        m_b = mq.pop_front();
        for (int i = 0; i < 8; i++) begin
          bm.push_back(m_b[7-i]);
          bl.push_back(m_b[i]);
        end
      end
      if (vin && !m_full) begin
        mq.push_back(din);
        acc.push_back(din);
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (en_cmp) begin
      chk("cycle_msb {rdy,valid,bit,busy}", {rdy_m, dv_m, dout_m, busy_m},
          {mq.size() < DEPTH, bm.size() != 0, (bm.size() != 0) ? bm[0] : 1'b0,
           (bm.size() != 0) || (mq.size() != 0)});
      chk("cycle_lsb {rdy,valid,bit,busy}", {rdy_l, dv_l, dout_l, busy_l},
          {mq.size() < DEPTH, bl.size() != 0, (bl.size() != 0) ? bl[0] : 1'b0,
           (bl.size() != 0) || (mq.size() != 0)});
    end
  end

  // Reassembles bytes from the MSB-first wire, like the downstream deserializer.
  int         mon_cnt = 0;
  logic [7:0] mon_byte;
  always @(negedge clk) begin
    if (rst) mon_cnt = 0;
    else if (dv_m === 1'b1) begin
      mon_byte = {mon_byte[6:0], dout_m};
      mon_cnt++;
      if (mon_cnt == 8) begin
        got.push_back(mon_byte);
        mon_cnt = 0;
      end
    end
  end

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(posedge clk); #1;
      done = (mq.size() == 0) && (bm.size() == 0);
    end
    chk("drain_timeout", done, 1'b1);
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic [7:0] exp_m;  // wire order, leftmost bit first
    logic [7:0] exp_l;
  } vec_t;
  vec_t vecs[6];

  logic [15:0] b2b_bits;
  bit          saw_full;
  bit          r;
  int          idx;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'h81, 8'b1000_0001, 8'b1000_0001};
    vecs[1] = '{8'h0D, 8'b0000_1101, 8'b1011_0000};
    vecs[2] = '{8'hA5, 8'b1010_0101, 8'b1010_0101};
    vecs[3] = '{8'h3C, 8'b0011_1100, 8'b0011_1100};
    vecs[4] = '{8'h96, 8'b1001_0110, 8'b0110_1001};
    vecs[5] = '{8'h01, 8'b0000_0001, 8'b1000_0000};
    b2b_bits = 16'b1000_0001_1000_0010;

    rst = 1'b1; vin = 1'b0; din = 8'h00;
    cyc();
    rst = 1'b0;
    en_cmp = 1'b1;
    @(negedge clk);
    chk("reset_state_msb", {rdy_m, dv_m, dout_m, busy_m}, 4'b1000);
    chk("reset_state_lsb", {rdy_l, dv_l, dout_l, busy_l}, 4'b1000);

    // Single bytes: one idle cycle after acceptance, then 8 valid bits, then idle.
    for (int v = 0; v < 6; v++) begin
      wait_idle();
      din = vecs[v].data; vin = 1'b1;
      cyc();
      vin = 1'b0; din = 8'($urandom);
      @(negedge clk);
      chk("latency_gap", {dv_m, dv_l}, 2'b00);
      for (int j = 0; j < 8; j++) begin
        @(negedge clk);
        chk("vec_bit_msb", {dv_m, dout_m}, {1'b1, vecs[v].exp_m[7-j]});
        chk("vec_bit_lsb", {dv_l, dout_l}, {1'b1, vecs[v].exp_l[7-j]});
      end
      @(negedge clk);
      chk("vec_end {valid,busy}", {dv_m, busy_m, dv_l, busy_l}, 4'b0000);
    end

    // Back-to-back 0x81, 0x82: 16 contiguous bits.
    wait_idle();
    got.delete();
    din = 8'h81; vin = 1'b1;
    cyc();
    din = 8'h82;
    cyc();
    vin = 1'b0;
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      chk("b2b_bit", {dv_m, dout_m}, {1'b1, b2b_bits[15-j]});
    end
    @(negedge clk);
    chk("b2b_end_valid", dv_m, 1'b0);
    chk("b2b_bytes", {got.size(), (got.size() == 2) ? {got[0], got[1]} : 16'h0}, {32'd2, 16'h8182});

    // Hold valid with 0x10..0x17; ready must drop and nothing may be lost.
    wait_idle();
    got.delete();
    idx = 0; saw_full = 1'b0;
    vin = 1'b1; din = 8'h10;
    for (int c = 0; c < 300 && idx < 8; c++) begin
      @(negedge clk);
      r = rdy_m;
      if (!r) saw_full = 1'b1;
      cyc();
      if (r) begin
        idx++;
        din = 8'h10 + 8'(idx);
      end
    end
    vin = 1'b0;
    chk("fill_all_accepted", idx, 8);
    chk("fill_ready_dropped", saw_full, 1'b1);
    wait_idle();
    chk("fill_count", got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++)
      chk("fill_byte", got[i], 8'h10 + 8'(i));

    // Reset after 3 bits of 0xA5 with two bytes queued.
    wait_idle();
    got.delete();
    din = 8'hA5; vin = 1'b1;
    cyc();
    din = 8'h11;
    cyc();
    din = 8'h22;
    cyc();
    vin = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_msb {rdy,valid,busy}", {rdy_m, dv_m, busy_m}, 3'b100);
    chk("rst_mid_lsb {rdy,valid,busy}", {rdy_l, dv_l, busy_l}, 3'b100);
    repeat (30) cyc();
    chk("rst_no_residue", got.size(), 0);
    din = 8'h3C; vin = 1'b1;
    cyc();
    vin = 1'b0;
    wait_idle();
    chk("rst_then_3c", {got.size(), (got.size() == 1) ? got[0] : 8'h00}, {32'd1, 8'h3C});

    // Valid toggling while data_in changes: only valid bytes appear.
    wait_idle();
    got.delete(); acc.delete();
    for (int c = 0; c < 400; c++) begin
      vin = 1'($urandom_range(0, 1));
      din = 8'($urandom);
      cyc();
    end
    vin = 1'b0;
    wait_idle();
    chk("toggle_count", got.size(), acc.size());
    for (int i = 0; i < acc.size() && i < got.size(); i++)
      chk("toggle_byte", got[i], acc[i]);

    // Long random run with occasional resets, checked cycle by cycle.
    for (int c = 0; c < 3000; c++) begin
      vin = ($urandom_range(0, 9) < 7);
      din = 8'($urandom);
      rst = ($urandom_range(0, 199) == 0);
      cyc();
    end
    rst = 1'b0; vin = 1'b0;
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
